// File: rtl/aemb_wb_memsim.sv
// Wishbone slave memory model for AEMB simulation benches, with wait states, byte lanes and service/fail detection.
// Define AEMB_MEMSIM_RANDSTALL_EN to add LFSR-driven random extra wait states (0..3) per request.
module aemb_wb_memsim #(
    parameter int          ASIZ      = 16,
    parameter int          WAIT_CYC  = 0,
    parameter int          CNTW      = 16,
    parameter logic [31:0] SVC_ADR   = 32'h0000_8888,
    parameter logic [31:0] SVC_WORD  = 32'h7A55ED00,
    parameter logic [31:0] FAIL_WORD = 32'hFA17ED00
) (
    input  logic            sys_clk_i,
    input  logic            sys_rst_i,
    input  logic [ASIZ-1:0] wb_adr_i,
    input  logic [31:0]     wb_dat_i,
    input  logic [3:0]      wb_sel_i,
    input  logic            wb_stb_i,
    input  logic            wb_wre_i,
    output logic [31:0]     wb_dat_o,
    output logic            wb_ack_o,
    output logic            svc_o,
    output logic            fail_o,
    output logic [CNTW-1:0] rd_cnt_o,
    output logic [CNTW-1:0] wr_cnt_o
);

    localparam int AW    = ASIZ - 2;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   wcnt;
    logic [CW-1:0]   wcnt_nxt;
    logic [CW-1:0]   stall_load;
    logic            latch;
    logic            commit;

    logic [AW-1:0]   req_adr;
    logic            req_wre;
    logic [3:0]      req_sel;
    logic [31:0]     req_dat;

    logic [31:0]     mem [DEPTH];

    logic            unused_adr_lsb;
    assign unused_adr_lsb = ^wb_adr_i[1:0];

`ifdef AEMB_MEMSIM_RANDSTALL_EN
    // Free-running Fibonacci LFSR (taps 16/14/13/11); its low bits add 0..3 stall cycles.
    logic [15:0] lfsr;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall_load = CW'(WAIT_CYC) + {{(CW-2){1'b0}}, lfsr[1:0]};
`else
    assign stall_load = CW'(WAIT_CYC);
`endif

    // The transfer commits at the edge that leaves ACK, so wb_ack_o is high the cycle after.
    assign commit = (state == ST_ACK);

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        latch     = 1'b0;
        case (state)
            ST_IDLE, ST_ACK: begin
                if (wb_stb_i) begin
                    latch     = 1'b1;
                    wcnt_nxt  = stall_load;
                    state_nxt = (stall_load == '0) ? ST_ACK : ST_WAIT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                wcnt_nxt = wcnt - 1'b1;
                if (wcnt <= CW'(1)) begin
                    state_nxt = ST_ACK;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state    <= ST_IDLE;
            wcnt     <= '0;
            req_adr  <= '0;
            req_wre  <= 1'b0;
            req_sel  <= '0;
            req_dat  <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            svc_o    <= 1'b0;
            fail_o   <= 1'b0;
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else begin
            state    <= state_nxt;
            wcnt     <= wcnt_nxt;
            wb_ack_o <= commit;
            svc_o    <= commit && req_wre && (req_adr == SVC_ADR[ASIZ-1:2]) &&
                        (req_sel == 4'hF) && (req_dat == SVC_WORD);
            if (latch) begin
                req_adr <= wb_adr_i[ASIZ-1:2];
                req_wre <= wb_wre_i;
                req_sel <= wb_sel_i;
                req_dat <= wb_dat_i;
            end
            if (commit) begin
                if (req_wre) begin
                    wr_cnt_o <= wr_cnt_o + 1'b1;
                    if (req_dat == FAIL_WORD) begin
                        fail_o <= 1'b1;
                    end
                end else begin
                    rd_cnt_o <= rd_cnt_o + 1'b1;
                    wb_dat_o <= mem[req_adr];
                end
            end
        end
    end

    // Storage is never cleared; a reset landing on a commit edge suppresses the write.
    always_ff @(posedge sys_clk_i) begin
        if (commit && req_wre && !sys_rst_i) begin
            for (int n = 0; n < 4; n++) begin
                if (req_sel[n]) begin
                    mem[req_adr][8*n +: 8] <= req_dat[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_aemb_wb_memsim.sv
// Self-checking bench for aemb_wb_memsim: one zero-wait instance and one 3-wait instance with 4-bit counters.
module tb_aemb_wb_memsim;

    localparam logic [31:0] SVC_WORD  = 32'h7A55ED00;
    localparam logic [31:0] FAIL_WORD = 32'hFA17ED00;
    localparam int          W1        = 3;
    localparam int          EW        = 97;  // {svc, issue cycle, due cycle, data}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst0, stb0, wre0, ack0, svc0, fail0;
    logic [15:0] adr0;
    logic [31:0] wdat0, rdat0;
    logic [3:0]  sel0;
    logic [15:0] rd0, wr0;

    logic        rst1, stb1, wre1, ack1, svc1, fail1;
    logic [15:0] adr1;
    logic [31:0] wdat1, rdat1;
    logic [3:0]  sel1;
    logic [3:0]  rd1, wr1;

    aemb_wb_memsim #(.ASIZ(16), .WAIT_CYC(0), .CNTW(16)) dut0 (
        .sys_clk_i(clk), .sys_rst_i(rst0), .wb_adr_i(adr0), .wb_dat_i(wdat0),
        .wb_sel_i(sel0), .wb_stb_i(stb0), .wb_wre_i(wre0), .wb_dat_o(rdat0),
        .wb_ack_o(ack0), .svc_o(svc0), .fail_o(fail0), .rd_cnt_o(rd0), .wr_cnt_o(wr0)
    );

    aemb_wb_memsim #(.ASIZ(16), .WAIT_CYC(W1), .CNTW(4)) dut1 (
        .sys_clk_i(clk), .sys_rst_i(rst1), .wb_adr_i(adr1), .wb_dat_i(wdat1),
        .wb_sel_i(sel1), .wb_stb_i(stb1), .wb_wre_i(wre1), .wb_dat_o(rdat1),
        .wb_ack_o(ack1), .svc_o(svc1), .fail_o(fail1), .rd_cnt_o(rd1), .wr_cnt_o(wr1)
    );

    // Scoreboard state: one expected queue per instance, a shared word model keyed by instance.
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [31:0]   mm [int];
    int            rd_n [2];
    int            wr_n [2];
    logic [31:0]   last_rd [2];
    bit            fail_m [2];
    int            last_lat0;
    int            n_chk = 0;
    int            n_err = 0;

`ifdef AEMB_MEMSIM_RANDSTALL_EN
    logic [15:0] lf0, lf1;
    always @(posedge clk or posedge rst0) begin
        if (rst0) lf0 <= 16'hACE1;
        else      lf0 <= {lf0[14:0], lf0[15] ^ lf0[13] ^ lf0[12] ^ lf0[10]};
    end
    always @(posedge clk or posedge rst1) begin
        if (rst1) lf1 <= 16'hACE1;
        else      lf1 <= {lf1[14:0], lf1[15] ^ lf1[13] ^ lf1[12] ^ lf1[10]};
    end
    function automatic int extra(input int d);
        return (d == 0) ? int'(lf0[1:0]) : int'(lf1[1:0]);
    endfunction
`else
    function automatic int extra(input int d);
        return 0 * d;
    endfunction
`endif

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int n = 0; n < 4; n++) begin
            if (sel[n]) r[8*n +: 8] = dat[8*n +: 8];
        end
        return r;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("drain", qsize(d), 0);
        if (d == 0) exp_q0.delete();
        else        exp_q1.delete();
    endtask

    // One request; stb is held for 'hold' extra edges beyond the sampling edge.
    task automatic bus_op(input int d, input bit wr, input logic [15:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int hold = 0);
        int            k, key, lat, ext;
        logic [31:0]   expd;
        bit            svc;
        logic [EW-1:0] e;
        @(negedge clk);
        ext = extra(d);
        if (d == 0) begin
            adr0 = adr; wdat0 = dat; sel0 = sel; wre0 = wr; stb0 = 1'b1;
        end else begin
            adr1 = adr; wdat1 = dat; sel1 = sel; wre1 = wr; stb1 = 1'b1;
        end
        @(posedge clk);
        #1;
        k   = cyc;
        key = (d << 16) | int'(adr[15:2]);
        lat = 1 + ((d == 0) ? 0 : W1) + ext;
        svc = wr && (adr[15:2] == 14'h2222) && (sel == 4'hF) && (dat == SVC_WORD);
        if (wr) begin
            mm[key] = merge(mm.exists(key) ? mm[key] : 32'hxxxx_xxxx, dat, sel);
            wr_n[d]++;
            if (dat == FAIL_WORD) fail_m[d] = 1'b1;
            expd = last_rd[d];
        end else begin
            expd = mm[key];
            last_rd[d] = expd;
            rd_n[d]++;
        end
        e = {svc, 32'(k), 32'(k + lat), expd};
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        repeat (hold) @(posedge clk);
        if (hold > 0) #1;
        if (d == 0) stb0 = 1'b0;
        else        stb1 = 1'b0;
`ifdef AEMB_MEMSIM_RANDSTALL_EN
        if (d == 0) wait_idle(0);
`endif
    endtask

    task automatic reset_dut(input int d);
        @(negedge clk);
        if (d == 0) rst0 = 1'b1;
        else        rst1 = 1'b1;
        rd_n[d] = 0; wr_n[d] = 0; last_rd[d] = '0; fail_m[d] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input int d, input string tag);
        if (d == 0) begin
            check({tag, "_dat0"}, rdat0, 0); check({tag, "_ack0"}, ack0, 0);
            check({tag, "_svc0"}, svc0, 0);  check({tag, "_fail0"}, fail0, 0);
            check({tag, "_rd0"}, rd0, 0);    check({tag, "_wr0"}, wr0, 0);
        end else begin
            check({tag, "_dat1"}, rdat1, 0); check({tag, "_ack1"}, ack1, 0);
            check({tag, "_svc1"}, svc1, 0);  check({tag, "_fail1"}, fail1, 0);
            check({tag, "_rd1"}, rd1, 0);    check({tag, "_wr1"}, wr1, 0);
        end
    endtask

    // Per-cycle monitor: ack and svc must appear exactly at the scheduled cycle.
    logic [EW-1:0] h0, h1;
    bit            due0, due1;
    always @(negedge clk) begin
        due0 = (exp_q0.size() > 0) && (exp_q0[0][63:32] == 32'(cyc));
        check("ack0", ack0, due0);
        check("svc0", svc0, due0 && exp_q0[0][96]);
        if (ack0 && due0) begin
            h0 = exp_q0.pop_front();
            check("rdat0", rdat0, h0[31:0]);
            last_lat0 = cyc - int'(h0[95:64]);
        end
        due1 = (exp_q1.size() > 0) && (exp_q1[0][63:32] == 32'(cyc));
        check("ack1", ack1, due1);
        check("svc1", svc1, due1 && exp_q1[0][96]);
        if (ack1 && due1) begin
            h1 = exp_q1.pop_front();
            check("rdat1", rdat1, h1[31:0]);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int lat_a [100];
    int lat_b [100];

    initial begin
        logic [31:0] d;
        logic [15:0] a;
        bit          w;
        rst0 = 1'b1; stb0 = 1'b0; wre0 = 1'b0; adr0 = '0; wdat0 = '0; sel0 = '0;
        rst1 = 1'b1; stb1 = 1'b0; wre1 = 1'b0; adr1 = '0; wdat1 = '0; sel1 = '0;
        for (int i = 0; i < 2; i++) begin
            rd_n[i] = 0; wr_n[i] = 0; last_rd[i] = '0; fail_m[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_zero(0, "rst");
        check_zero(1, "rst");
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;

        // Write then read one word with full lanes.
        bus_op(0, 1, 16'h0010, 32'h12345678, 4'hF);
        bus_op(0, 0, 16'h0010, 32'h0, 4'h0);
        wait_idle(0);
        check("t1_rdat", rdat0, 32'h12345678);
        check("t1_wr_cnt", wr0, 1);
        check("t1_rd_cnt", rd0, 1);

        // Partial-lane write back-to-back with the read of the same word.
        bus_op(0, 1, 16'h0020, 32'hAABBCCDD, 4'hF);
        bus_op(0, 1, 16'h0020, 32'h11223344, 4'b0101);
        bus_op(0, 0, 16'h0020, 32'h0, 4'hF);
        wait_idle(0);
        check("t2_rdat", rdat0, 32'hAA22CC44);

        // Random lanes and addresses over a preloaded window, low address bits varied.
        for (int i = 0; i < 8; i++) bus_op(0, 1, 16'(16'h0100 + 4 * i), $urandom, 4'hF);
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 16'(16'h0100 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3));
            d = $urandom;
            if (d == FAIL_WORD || d == SVC_WORD) d = d ^ 32'h1;
            bus_op(0, w, a, d, 4'($urandom_range(1, 15)));
        end
        wait_idle(0);
        check("rnd_wr_cnt", wr0, 16'(wr_n[0]));
        check("rnd_rd_cnt", rd0, 16'(rd_n[0]));

        // Service detection, two near misses, then the sticky fail flag.
        bus_op(0, 1, 16'h8888, SVC_WORD, 4'hF);
        bus_op(0, 1, 16'h8888, SVC_WORD, 4'h7);
        bus_op(0, 1, 16'h888C, SVC_WORD, 4'hF);
        wait_idle(0);
        check("t4_fail_pre", fail0, fail_m[0]);
        bus_op(0, 1, 16'h0004, FAIL_WORD, 4'h2);
        wait_idle(0);
        check("t4_fail_set", fail0, fail_m[0]);
        bus_op(0, 0, 16'h0010, 32'h0, 4'hF);
        bus_op(0, 1, 16'h0014, 32'h5A5A5A5A, 4'hF);
        wait_idle(0);
        check("t4_fail_hold", fail0, 1);
        reset_dut(0);
        check_zero(0, "t4_rst");
        rst0 = 1'b0;

        // Latency profile over two runs from reset; must be in range and repeatable.
        for (int run = 0; run < 2; run++) begin
            for (int i = 0; i < 100; i++) begin
                bus_op(0, 0, 16'(16'h0100 + 4 * (i % 8)), 32'h0, 4'hF);
                wait_idle(0);
                if (run == 0) lat_a[i] = last_lat0;
                else          lat_b[i] = last_lat0;
            end
            check("t6_rd_cnt", rd0, 16'(rd_n[0]));
            reset_dut(0);
            rst0 = 1'b0;
        end
        for (int i = 0; i < 100; i++) begin
            check("t6_lat_range", (lat_a[i] >= 1) && (lat_a[i] <= 4), 1);
            check("t6_lat_repeat", lat_b[i], lat_a[i]);
        end

        // Wait-state instance: strobe held through WAIT counts once.
        bus_op(1, 1, 16'h0040, 32'hCAFEF00D, 4'hF);
        wait_idle(1);
        bus_op(1, 0, 16'h0040, 32'h0, 4'hF, W1);
        wait_idle(1);
        check("t3_rdat", rdat1, 32'hCAFEF00D);
        check("t3_rd_cnt", rd1, 4'(rd_n[1]));

        // Reset during WAIT of a write abandons it.
        bus_op(1, 1, 16'h0030, 32'h0BADBEEF, 4'hF);
        wait_idle(1);
        @(negedge clk);
        adr1 = 16'h0030; wdat1 = 32'h12121212; sel1 = 4'hF; wre1 = 1'b1; stb1 = 1'b1;
        @(posedge clk);
        #1;
        stb1 = 1'b0;
        @(posedge clk);
        #1;
        rst1 = 1'b1;
        rd_n[1] = 0; wr_n[1] = 0; last_rd[1] = '0; fail_m[1] = 1'b0;
        repeat (2) @(negedge clk);
        check_zero(1, "t5_rst");
        rst1 = 1'b0;
        bus_op(1, 0, 16'h0030, 32'h0, 4'hF);
        wait_idle(1);
        check("t5_rdat", rdat1, 32'h0BADBEEF);

        // Counter wrap on the 4-bit instance.
        for (int i = 0; i < 17; i++) begin
            bus_op(1, 0, 16'h0040, 32'h0, 4'hF);
            wait_idle(1);
        end
        for (int i = 0; i < 3; i++) begin
            bus_op(1, 1, 16'h0044, 32'(i), 4'hF);
            wait_idle(1);
        end
        check("wrap_rd_cnt", rd1, 4'(rd_n[1]));
        check("wrap_wr_cnt", wr1, 4'(wr_n[1]));

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
